// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: holds the architectural NZCV flags, evaluates the
// condition field against them, and queues register-file writes in a small
// FIFO so the ALU can keep issuing while the register file is busy.
module exec_wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [3:0]                 in_flags,
  input  logic [3:0]                 in_rd,
  input  logic                       in_wr_reg,
  input  logic                       in_set_flags,
  output logic [3:0]                 flag,
  input  logic [3:0]                 cond,
  output logic                       cond_pass,
  output logic                       rf_we,
  output logic [3:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  input  logic                       rf_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  // Pointer width stays at least one bit so a degenerate DEPTH still elaborates.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [35:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    flag_q, flag_d;

  logic accept;
  logic push;
  logic pop;
  logic [35:0] head;

  logic n_f, z_f, c_f, v_f;

  // Handshake and queue bookkeeping; flush overrides everything except the flags.
  always_comb begin
    in_ready = (count_q < DEPTH_C) & ~flush;
    accept   = in_valid & in_ready;
    push     = accept & in_wr_reg;
    pop      = (count_q != '0) & rf_ready & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags follow any accepted instruction that sets them, whether or not it writes a register.
  always_comb begin
    flag_d = flag_q;
    if (accept && in_set_flags) flag_d = in_flags;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flag_q   <= 4'b0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Queue storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_rd, in_result};
  end

  // Register-file port driven purely from stored state.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    rf_we    = (count_q != '0);
    rf_waddr = head[35:32];
    rf_wdata = head[31:0];
    count    = count_q;
    flag     = flag_q;
  end

  // Condition evaluation against the registered flags.
  always_comb begin
    n_f = flag_q[3];
    z_f = flag_q[2];
    c_f = flag_q[1];
    v_f = flag_q[0];
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = ~z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = ~c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = ~n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = ~v_f;
      4'h8: cond_pass = c_f & ~z_f;
      4'h9: cond_pass = ~c_f | z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = ~z_f & (n_f == v_f);
      4'hD: cond_pass = z_f | (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
module tb_exec_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_rd;
  logic        in_wr_reg;
  logic        in_set_flags;
  logic [3:0]  flag;
  logic [3:0]  cond;
  logic        cond_pass;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic        flush;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  exec_wb_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
    .in_wr_reg(in_wr_reg), .in_set_flags(in_set_flags),
    .flag(flag), .cond(cond), .cond_pass(cond_pass),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_ready(rf_ready), .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_result = 0; in_flags = 0; in_rd = 0;
    in_wr_reg = 0; in_set_flags = 0; cond = 0; rf_ready = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_flag", flag, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // single write, one-cycle latency
    in_valid = 1; in_rd = 4'd3; in_result = 32'h5; in_wr_reg = 1; rf_ready = 1;
    step();
    in_valid = 0; in_wr_reg = 0;
    chk("lat_rf_we", rf_we, 1);
    chk("lat_waddr", rf_waddr, 3);
    chk("lat_wdata", rf_wdata, 5);
    chk("lat_count", count, 1);
    step();
    chk("lat_drain_count", count, 0);
    chk("lat_drain_we", rf_we, 0);

    // fill under backpressure, third held, then ordered drain
    rf_ready = 0;
    in_valid = 1; in_wr_reg = 1; in_rd = 4'd1; in_result = 32'hA;
    step();
    chk("fill1_count", count, 1);
    in_rd = 4'd2; in_result = 32'hB;
    step();
    chk("fill2_count", count, 2);
    chk("fill2_in_ready", in_ready, 0);
    in_rd = 4'd4; in_result = 32'hC;
    step();
    chk("stall_count", count, 2);
    chk("stall_wdata", rf_wdata, 32'hA);
    chk("stall_waddr", rf_waddr, 1);
    rf_ready = 1;
    chk("pop_full_in_ready", in_ready, 0);
    step();
    chk("drain_b_wdata", rf_wdata, 32'hB);
    chk("drain_b_count", count, 1);
    chk("drain_b_in_ready", in_ready, 1);
    step();
    in_valid = 0; in_wr_reg = 0;
    chk("drain_c_wdata", rf_wdata, 32'hC);
    chk("drain_c_waddr", rf_waddr, 4);
    chk("drain_c_count", count, 1);
    step();
    chk("drain_end_count", count, 0);

    // flags-only instruction and condition evaluation
    in_valid = 1; in_set_flags = 1; in_flags = 4'b0100; in_wr_reg = 0;
    step();
    in_valid = 0; in_set_flags = 0;
    chk("flags_only_flag", flag, 4'b0100);
    chk("flags_only_count", count, 0);
    cond = 4'h0; #1 chk("cond_eq", cond_pass, 1);
    cond = 4'h1; #1 chk("cond_ne", cond_pass, 0);
    cond = 4'h8; #1 chk("cond_hi", cond_pass, 0);
    cond = 4'h9; #1 chk("cond_ls", cond_pass, 1);
    cond = 4'hC; #1 chk("cond_gt", cond_pass, 0);
    cond = 4'hE; #1 chk("cond_al", cond_pass, 1);
    cond = 4'hF; #1 chk("cond_nv", cond_pass, 0);

    // steady push+pop at count=1, pointers wrap several times
    rf_ready = 0;
    in_valid = 1; in_wr_reg = 1; in_rd = 4'd0; in_result = 32'h100;
    step();
    chk("stream_prime_count", count, 1);
    rf_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stream_wdata_%0d", i), rf_wdata, 32'h100 + i);
      chk($sformatf("stream_waddr_%0d", i), rf_waddr, i % 16);
      in_rd = 4'(i + 1); in_result = 32'h101 + i;
      step();
      chk($sformatf("stream_count_%0d", i), count, 1);
    end
    in_valid = 0; in_wr_reg = 0;
    chk("stream_last_wdata", rf_wdata, 32'h108);
    step();
    chk("stream_end_count", count, 0);

    // flush keeps flags
    rf_ready = 0;
    in_valid = 1; in_wr_reg = 1; in_set_flags = 1; in_flags = 4'b1001;
    in_rd = 4'd7; in_result = 32'h77;
    step();
    in_set_flags = 0; in_rd = 4'd8; in_result = 32'h88;
    step();
    in_valid = 0; in_wr_reg = 0;
    chk("pre_flush_count", count, 2);
    flush = 1; rf_ready = 1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 0; rf_ready = 0;
    chk("flush_count", count, 0);
    chk("flush_rf_we", rf_we, 0);
    chk("flush_flag", flag, 4'b1001);
    cond = 4'hA; #1 chk("cond_ge", cond_pass, 1);
    cond = 4'hD; #1 chk("cond_le", cond_pass, 0);
    in_valid = 1; in_wr_reg = 1; in_rd = 4'd9; in_result = 32'h99;
    step();
    in_valid = 0; in_wr_reg = 0;
    chk("post_flush_wdata", rf_wdata, 32'h99);
    chk("post_flush_count", count, 1);

    // async reset mid-stall
    in_valid = 1; in_wr_reg = 1; in_set_flags = 1; in_flags = 4'b0110;
    in_rd = 4'd5; in_result = 32'h55;
    step();
    in_valid = 0; in_wr_reg = 0; in_set_flags = 0;
    chk("pre_rst_count", count, 2);
    chk("pre_rst_flag", flag, 4'b0110);
    #2 rst_n = 0;
    #1;
    chk("async_rst_we", rf_we, 0);
    chk("async_rst_flag", flag, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_in_ready", in_ready, 1);
    step();
    rst_n = 1;
    step();
    chk("post_rst_we", rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
